// File: rtl/reset_sequencer.sv
// reset_sequencer: releases per-subsystem resets in a fixed order with programmable spacing.
//   clk            system clock
//   rstn           asynchronous active-low reset
//   sys_ready_i    clocks+DDR stable level from upstream, synchronized internally
//   soft_rst_req_i four-phase soft-reset request
//   soft_rst_ack_o soft-reset acknowledge
//   stage_rst_o    active-high reset per stage (0 memory, 1 bus, 2 CPU)
//   all_released_o every stage out of reset
//   state_o        0 HOLD, 1 RELEASE, 2 RUN, 3 SOFT
//   wdt_timeout_o  sticky HOLD watchdog flag, only with RESET_SEQ_WDT_EN defined
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_DELAY   = 16,
    parameter int SYNC_DEPTH    = 2,
    parameter int SOFT_RST_HOLD = 8,
    parameter int WDT_LIMIT     = 1048576
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sys_ready_i,
    input  logic                  soft_rst_req_i,
    output logic                  soft_rst_ack_o,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  all_released_o,
    output logic [1:0]            state_o,
    output logic                  wdt_timeout_o
);
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_REL  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_SOFT = 2'd3;
    localparam int MAXD = STAGE_DELAY > SOFT_RST_HOLD ? STAGE_DELAY : SOFT_RST_HOLD;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int IW   = $clog2(NUM_STAGES + 1);
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  rdy_s;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic                  soft_active_q;
    assign rdy_s = sync_q[SYNC_DEPTH-1];
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_DEPTH-2:0], sys_ready_i};
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_o        <= S_HOLD;
            stage_rst_o    <= '1;
            all_released_o <= 1'b0;
            soft_rst_ack_o <= 1'b0;
            cnt_q          <= '0;
            idx_q          <= '0;
            soft_active_q  <= 1'b0;
        end else begin
            // ack drops once the requester lowers req; a later set below wins
            if (soft_rst_ack_o && !soft_rst_req_i) soft_rst_ack_o <= 1'b0;
            case (state_o)
                S_HOLD: begin
                    stage_rst_o    <= '1;
                    all_released_o <= 1'b0;
                    if (rdy_s) begin
                        state_o <= S_REL;
                        cnt_q   <= CW'(STAGE_DELAY - 1);
                        idx_q   <= '0;
                    end
                end
                S_REL: begin
                    if (!rdy_s) begin
                        state_o        <= S_HOLD;
                        stage_rst_o    <= '1;
                        all_released_o <= 1'b0;
                        cnt_q          <= '0;
                        idx_q          <= '0;
                    end else if (idx_q == IW'(NUM_STAGES)) begin
                        state_o        <= S_RUN;
                        all_released_o <= 1'b1;
                        if (soft_active_q) begin
                            soft_rst_ack_o <= 1'b1;
                            soft_active_q  <= 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        stage_rst_o <= stage_rst_o & ~(NUM_STAGES'(1) << idx_q);
                        idx_q       <= idx_q + 1'b1;
                        cnt_q       <= CW'(STAGE_DELAY - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!rdy_s) begin
                        state_o        <= S_HOLD;
                        stage_rst_o    <= '1;
                        all_released_o <= 1'b0;
                        cnt_q          <= '0;
                        idx_q          <= '0;
                    end else if (soft_rst_req_i && !soft_rst_ack_o) begin
                        state_o        <= S_SOFT;
                        soft_active_q  <= 1'b1;
                        stage_rst_o    <= '1;
                        all_released_o <= 1'b0;
                        cnt_q          <= CW'(SOFT_RST_HOLD - 1);
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rdy_s) begin
                        state_o <= S_REL;
                        cnt_q   <= CW'(STAGE_DELAY - 1);
                        idx_q   <= '0;
                    end else begin
                        state_o <= S_HOLD;
                        idx_q   <= '0;
                    end
                end
            endcase
        end
    end
`ifdef RESET_SEQ_WDT_EN
    localparam int WW = $clog2(WDT_LIMIT + 1);
    logic [WW-1:0] wdt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_q         <= '0;
            wdt_timeout_o <= 1'b0;
        end else if (state_o == S_HOLD) begin
            if (wdt_q != WW'(WDT_LIMIT)) wdt_q <= wdt_q + 1'b1;
            if (wdt_q == WW'(WDT_LIMIT - 1)) wdt_timeout_o <= 1'b1;
        end else begin
            wdt_q <= '0;
        end
    end
`else
    // constant 0; the comparison only keeps WDT_LIMIT referenced
    assign wdt_timeout_o = WDT_LIMIT < 0;
`endif
endmodule
